// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared encodings and constants for the MEM pipeline stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = 4'd15;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Reserved encoding behaves like "no memory access".
    function automatic logic is_access(input logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Data-memory request FSM with ack timeout and stall generation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_access_ctrl
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_op_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic              stall_o,
    output logic              mem_error_o
);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              w_start;
    logic              w_pending;

    assign w_start   = (state_q == ST_IDLE) && is_access(mem_op_i);
    assign w_pending = (state_q == ST_WAIT) && !dmem_ack_i;
    assign stall_o   = rst_n && (w_start || w_pending);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = (mem_op_i == MEM_STORE);
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            ST_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else begin
                    // Giving up when the count reaches the limit caps the wait at 15 cycles.
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TIMEOUT_LIMIT) begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign mem_error_o  = err_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : MEM pipeline stage: branch resolution, data-memory access, MEM/WB.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] data_1_in,
    input  logic [DATA_W-1:0] data_2_in,
    input  logic [REG_W-1:0]  reg_dst_result_in,
    input  logic              beq_in,
    input  logic              bne_in,
    input  logic [1:0]        mem_op_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              compare_in,
    input  logic [DATA_W-1:0] address_in,
    input  logic              address_src_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              flush,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg_dst,
    output logic              wb_reg_write,
    output logic              mem_error
);

    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [REG_W-1:0]  wb_reg_dst_q, wb_reg_dst_d;
    logic              wb_reg_write_q, wb_reg_write_d;

    dmem_access_ctrl u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_op_i     (mem_op_in),
        .addr_i       (alu_result_in),
        .wdata_i      (data_2_in),
        .dmem_ack_i   (dmem_ack),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .stall_o      (stall),
        .mem_error_o  (mem_error)
    );

    assign branch_taken  = (beq_in & compare_in) | (bne_in & ~compare_in);
    assign branch_target = address_src_in ? data_1_in : address_in;
    assign flush         = branch_taken;

    // stall is low only for a non-memory op in IDLE or the ack cycle, so those are the capture points.
    always_comb begin
        wb_data_d      = mem_to_reg_in ? dmem_rdata : alu_result_in;
        wb_reg_dst_d   = reg_dst_result_in;
        wb_reg_write_d = reg_write_in;
        if (stall) begin
            wb_data_d      = '0;
            wb_reg_dst_d   = '0;
            wb_reg_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q      <= '0;
            wb_reg_dst_q   <= '0;
            wb_reg_write_q <= 1'b0;
        end else begin
            wb_data_q      <= wb_data_d;
            wb_reg_dst_q   <= wb_reg_dst_d;
            wb_reg_write_q <= wb_reg_write_d;
        end
    end

    assign wb_data      = wb_data_q;
    assign wb_reg_dst   = wb_reg_dst_q;
    assign wb_reg_write = wb_reg_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage (vector table, directed, random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alu_result_in, data_1_in, data_2_in, address_in, dmem_rdata;
    logic [2:0]  reg_dst_result_in;
    logic        beq_in, bne_in, mem_to_reg_in, reg_write_in, compare_in, address_src_in;
    logic [1:0]  mem_op_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, branch_taken, flush, wb_reg_write, mem_error;
    logic [15:0] dmem_addr, dmem_wdata, branch_target, wb_data;
    logic [2:0]  wb_reg_dst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result_in(alu_result_in), .data_1_in(data_1_in), .data_2_in(data_2_in),
        .reg_dst_result_in(reg_dst_result_in), .beq_in(beq_in), .bne_in(bne_in),
        .mem_op_in(mem_op_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .compare_in(compare_in), .address_in(address_in), .address_src_in(address_src_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush),
        .wb_data(wb_data), .wb_reg_dst(wb_reg_dst), .wb_reg_write(wb_reg_write),
        .mem_error(mem_error)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string name);
        chk16({name, "_wbdata"}, wb_data, 16'h0000);
        chk16({name, "_wbdst"}, 16'(wb_reg_dst), 16'h0000);
        chk1({name, "_wbwr"}, wb_reg_write, 1'b0);
    endtask

    // One load/store; delay = WAIT cycles without ack before ack (>=15 means timeout).
    task automatic run_mem(input logic [1:0] op, input int delay, input logic [15:0] alu,
                           input logic [15:0] d2, input logic [15:0] rd, input logic [2:0] dst,
                           input logic rw, input logic m2r, output int nstall);
        logic exp_we;
        exp_we = (op == MEM_STORE);
        nstall = 0;
        mem_op_in = op; alu_result_in = alu; data_2_in = d2; reg_dst_result_in = dst;
        reg_write_in = rw; mem_to_reg_in = m2r; beq_in = 1'b0; bne_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
        #1;
        chk1("issue_stall", stall, 1'b1);
        if (stall) nstall++;
        tick();
        chk_bubble("issue");
        chk1("req", dmem_req, 1'b1);
        chk1("we", dmem_we, exp_we);
        chk16("addr", dmem_addr, alu);
        chk16("wdata", dmem_wdata, d2);
        for (int k = 1; k <= 15; k++) begin
            if (k == delay + 1) begin
                dmem_ack = 1'b1; dmem_rdata = rd;
                #1;
                chk1("ack_stall", stall, 1'b0);
                tick();
                dmem_ack = 1'b0;
                chk16("ack_wbdata", wb_data, m2r ? rd : alu);
                chk16("ack_wbdst", 16'(wb_reg_dst), 16'(dst));
                chk1("ack_wbwr", wb_reg_write, rw);
                chk1("ack_req", dmem_req, 1'b0);
                chk1("ack_err", mem_error, 1'b0);
                mem_op_in = MEM_NONE; reg_write_in = 1'b0;
                return;
            end
            #1;
            chk1("wait_stall", stall, 1'b1);
            if (stall) nstall++;
            tick();
            chk_bubble("wait");
            if (k < 15) begin
                chk1("wait_req", dmem_req, 1'b1);
                chk16("wait_addr", dmem_addr, alu);
                chk1("wait_err", mem_error, 1'b0);
            end else begin
                chk1("to_req", dmem_req, 1'b0);
                chk1("to_err", mem_error, 1'b1);
            end
        end
        mem_op_in = MEM_NONE; reg_write_in = 1'b0;
        #1;
        chk1("post_to_stall", stall, 1'b0);
        tick();
        chk1("post_to_err", mem_error, 1'b0);
        chk1("post_to_req", dmem_req, 1'b0);
    endtask

    typedef struct {
        logic        beq, bne, cmp, asrc;
        logic [15:0] addr, d1, alu, rdata;
        logic [2:0]  dst;
        logic        rw, m2r;
        logic        exp_taken;
        logic [15:0] exp_target, exp_wb;
    } vec_t;

    vec_t vt[6];

    initial begin
        int n;
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h5555, 16'h0007, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0007};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0200, 16'h0300, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0ABC, 16'hFFFF, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b1, 16'h0ABC, 16'hFFFF};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h4321, 16'h9999, 3'd5, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h9999};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000};

        rst_n = 1'b0;
        alu_result_in = '0; data_1_in = '0; data_2_in = '0; address_in = '0; dmem_rdata = '0;
        reg_dst_result_in = '0; beq_in = 0; bne_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
        compare_in = 0; address_src_in = 0; dmem_ack = 0;
        mem_op_in = MEM_LOAD;
        #2;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_req", dmem_req, 1'b0);
        chk16("rst_addr", dmem_addr, 16'h0000);
        chk16("rst_wbdata", wb_data, 16'h0000);
        chk1("rst_wbwr", wb_reg_write, 1'b0);
        chk1("rst_err", mem_error, 1'b0);
        mem_op_in = MEM_NONE;
        tick(); tick();
        rst_n = 1'b1;

        // Non-memory instructions and branch resolution; ack in IDLE must be ignored.
        for (int i = 0; i < 6; i++) begin
            beq_in = vt[i].beq; bne_in = vt[i].bne; compare_in = vt[i].cmp;
            address_src_in = vt[i].asrc; address_in = vt[i].addr; data_1_in = vt[i].d1;
            alu_result_in = vt[i].alu; dmem_rdata = vt[i].rdata; reg_dst_result_in = vt[i].dst;
            reg_write_in = vt[i].rw; mem_to_reg_in = vt[i].m2r; mem_op_in = MEM_NONE;
            dmem_ack = (i % 2 == 1);
            #1;
            chk1("vec_taken", branch_taken, vt[i].exp_taken);
            chk1("vec_flush", flush, vt[i].exp_taken);
            chk16("vec_target", branch_target, vt[i].exp_target);
            chk1("vec_stall", stall, 1'b0);
            tick();
            chk16("vec_wbdata", wb_data, vt[i].exp_wb);
            chk16("vec_wbdst", 16'(wb_reg_dst), 16'(vt[i].dst));
            chk1("vec_wbwr", wb_reg_write, vt[i].rw);
            chk1("vec_req", dmem_req, 1'b0);
            chk1("vec_err", mem_error, 1'b0);
        end
        dmem_ack = 1'b0;

        run_mem(MEM_LOAD, 3, 16'h0040, 16'h0000, 16'hBEEF, 3'd4, 1'b1, 1'b1, n);
        chk16("load_stall_cycles", 16'(n), 16'd4);
        run_mem(MEM_STORE, 0, 16'h0010, 16'h00AA, 16'h1111, 3'd2, 1'b0, 1'b0, n);
        chk16("store_stall_cycles", 16'(n), 16'd1);
        run_mem(MEM_LOAD, 20, 16'h0080, 16'h0000, 16'h2222, 3'd1, 1'b1, 1'b1, n);
        chk16("timeout_stall_cycles", 16'(n), 16'd16);
        run_mem(MEM_LOAD, 14, 16'h0090, 16'h0000, 16'h3333, 3'd6, 1'b1, 1'b1, n);
        chk16("ack15_stall_cycles", 16'(n), 16'd15);

        // Reset during the second WAIT cycle.
        mem_op_in = MEM_LOAD; alu_result_in = 16'h0050; reg_write_in = 1'b1; dmem_ack = 1'b0;
        tick(); tick();
        beq_in = 1'b1; compare_in = 1'b1; address_src_in = 1'b0; address_in = 16'h0100;
        rst_n = 1'b0;
        #1;
        chk1("rstw_req", dmem_req, 1'b0);
        chk1("rstw_err", mem_error, 1'b0);
        chk1("rstw_stall", stall, 1'b0);
        chk1("rstw_taken", branch_taken, 1'b1);
        chk16("rstw_target", branch_target, 16'h0100);
        tick();
        chk1("rstw_err2", mem_error, 1'b0);
        beq_in = 1'b0; mem_op_in = MEM_NONE; alu_result_in = 16'h7777;
        reg_dst_result_in = 3'd6; mem_to_reg_in = 1'b0;
        rst_n = 1'b1;
        #1;
        chk1("rstw_idle_stall", stall, 1'b0);
        tick();
        chk16("rstw_wbdata", wb_data, 16'h7777);
        chk1("rstw_req2", dmem_req, 1'b0);

        // Random mix against the instruction-level model.
        for (int it = 0; it < 40; it++) begin
            logic [1:0]  op;
            logic [15:0] a, d1, d2, ad, rd;
            logic [2:0]  dst;
            logic        rw, m2r, bq, bn, cp, as, exp_tk;
            int          dly;
            op = 2'($urandom_range(0, 3));
            a = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
            ad = 16'($urandom); rd = 16'($urandom); dst = 3'($urandom);
            rw = 1'($urandom); m2r = 1'($urandom);
            if (is_access(op)) begin
                dly = $urandom_range(0, 17);
                run_mem(op, dly, a, d2, rd, dst, rw, m2r, n);
                chk16("rnd_stall_cycles", 16'(n), 16'((dly < 15) ? dly + 1 : 16));
            end else begin
                bq = 1'($urandom); bn = 1'($urandom); cp = 1'($urandom); as = 1'($urandom);
                exp_tk = bq ? cp : 1'b0;
                if (bn && !cp) exp_tk = 1'b1;
                beq_in = bq; bne_in = bn; compare_in = cp; address_src_in = as;
                address_in = ad; data_1_in = d1; alu_result_in = a; data_2_in = d2;
                dmem_rdata = rd; reg_dst_result_in = dst; reg_write_in = rw;
                mem_to_reg_in = m2r; mem_op_in = op; dmem_ack = 1'($urandom);
                #1;
                chk1("rnd_taken", branch_taken, exp_tk);
                chk1("rnd_flush", flush, exp_tk);
                chk16("rnd_target", branch_target, as ? d1 : ad);
                chk1("rnd_stall", stall, 1'b0);
                tick();
                dmem_ack = 1'b0;
                chk16("rnd_wbdata", wb_data, m2r ? rd : a);
                chk16("rnd_wbdst", 16'(wb_reg_dst), 16'(dst));
                chk1("rnd_wbwr", wb_reg_write, rw);
                chk1("rnd_req", dmem_req, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
